rvlab_jtag_host: RTL
====================

RVLAB_JTAG_HOST -- requirements
Module: rvlab_jtag_host

Interface
REQ-001 SHALL have parameter ClkDiv, default 2: TCK half-period in clk_i cycles, legal range 1..255.
REQ-002 SHALL have port clk_i  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port trst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid_i  input  1  command request.
REQ-005 SHALL have port cmd_ready_o  output  1  host idle; the command is accepted when cmd_valid_i and cmd_ready_o are both high.
REQ-006 SHALL have port cmd_op_i  input  2  operation: 0 RESET, 1 IRSCAN, 2 DRSCAN, 3 IDLE.
REQ-007 SHALL have port cmd_len_i  input  6  scan length in bits, or idle TCK count.
REQ-008 SHALL have port cmd_data_i  input  41  TDI data, shifted LSB first.
REQ-009 SHALL have port rsp_valid_o  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_data_o  output  41  captured TDO bits, LSB first.
REQ-011 SHALL have port tck_o  output  1  JTAG test clock.
REQ-012 SHALL have port tms_o  output  1  JTAG test mode select.
REQ-013 SHALL have port tdi_o  output  1  JTAG test data to the TAP.
REQ-014 SHALL have port tdo_i  input  1  JTAG test data from the TAP; the TAP updates it on the TCK falling edge.

Function
REQ-015 SHALL hold tck_o low when idle; each TCK period is a low phase of ClkDiv clk_i cycles followed by a high phase of ClkDiv clk_i cycles.
REQ-016 SHALL update tms_o and tdi_o only in the clk_i cycle in which tck_o goes low, or at period start.
REQ-017 SHALL sample tdo_i in the clk_i cycle in which tck_o transitions 0->1.
REQ-018 SHALL use states IDLE, HDR, SHIFT, TRL and DONE.
REQ-019 In IDLE, SHALL drive cmd_ready_o=1; on accept, SHALL latch op, len and data, clear rsp_data_o, and go to HDR.
REQ-020 SHALL assume the TAP is in Run-Test/Idle at the start of every command; RESET leaves the TAP in Run-Test/Idle.
REQ-021 RESET SHALL emit TMS sequence 1,1,1,1,1,0 (6 periods) with tdi_o=0, capturing no data.
REQ-022 DRSCAN SHALL emit HDR TMS 1,0,0, then SHIFT.
REQ-023 IRSCAN SHALL emit HDR TMS 1,1,0,0, then SHIFT.
REQ-024 In SHIFT, bit i SHALL drive tdi_o=data[i] for i=0..N-1.
REQ-025 In SHIFT, tms_o SHALL be 0 except on bit N-1, where it is 1.
REQ-026 In SHIFT, the tdo_i value sampled on bit i's rising edge SHALL be stored to rsp_data_o[i].
REQ-027 For scans, TRL SHALL emit TMS 1,0 (Update, then Run-Test/Idle).
REQ-028 Total TCK periods SHALL be N+5 for DRSCAN and N+6 for IRSCAN.
REQ-029 IDLE SHALL emit cmd_len_i periods with TMS=0.
REQ-030 An IDLE command with len=0 SHALL emit no TCK and respond in the next cycle.
REQ-031 For scans, N=0 SHALL be treated as 1, and N>41 SHALL be clamped to 41.
REQ-032 rsp_data_o bits at index N and above SHALL be 0.
REQ-033 rsp_data_o bits SHALL be 0 for RESET and IDLE commands.
REQ-034 DONE SHALL be entered in the clk_i cycle after the last high phase ends with tck_o already low.
REQ-035 In DONE, SHALL pulse rsp_valid_o for exactly 1 cycle and return to IDLE.
REQ-036 cmd_ready_o SHALL rise in the cycle after rsp_valid_o.
REQ-037 rsp_data_o SHALL be stable from rsp_valid_o until the next accept.
REQ-038 cmd_valid_i while busy SHALL be ignored (cmd_ready_o=0); no command is queued.
REQ-039 Cycle count: ClkDiv cycles per TCK phase; 2*ClkDiv*periods plus 2 overhead cycles from accept to rsp_valid_o.

Reset
REQ-040 On trst_ni low, at any time including mid-scan, SHALL force tck_o=0, tms_o=1, tdi_o=0, cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=0, state IDLE, and divider=0.
REQ-041 A scan aborted by reset SHALL produce no rsp_valid_o.
REQ-042 After reset, software SHALL issue a RESET command before any scan.

Verification
REQ-043 Bench: TAP model (IrLength 5, IDCODE default), ClkDiv=2; RESET, then DRSCAN len=32 -> rsp_data_o[31:0]=IdcodeValue, [40:32]=0, rsp_valid_o 150 clk_i cycles after accept.
REQ-044 Bench: IRSCAN len=5, data=0x11 -> rsp_data_o=0x05 (capture pattern); then DRSCAN len=32 -> rsp_data_o=0x00001071 (version 1, abits 7, idle 1, dmistat 0).
REQ-045 Bench: IRSCAN data=0x1F (bypass), then DRSCAN len=8, data=0xA5 -> rsp_data_o=0x4A.
REQ-046 Bench: cmd_valid_i held high during a scan -> exactly one accept; a second command is accepted only in the cycle after rsp_valid_o.
REQ-047 Bench: trst_ni asserted at SHIFT bit 10 -> outputs match reset values immediately, no rsp_valid_o; then RESET followed by an IDCODE read -> correct value.
REQ-048 Bench: IDLE len=0 -> rsp_valid_o 2 cycles after accept with tck_o constant 0; IDLE len=3 -> exactly 3 TCK pulses with tms_o=0.

Source files
------------

// File: rtl/rvlab_jtag_host.sv
//------------------------------------------------------------------------------
// rvlab_jtag_host : command-driven JTAG master (TAP reset, IR/DR scans, idle clocks)
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rvlab_jtag_host #(
    parameter int unsigned ClkDiv = 2
) (
    input  logic        clk_i,
    input  logic        trst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [5:0]  cmd_len_i,
    input  logic [40:0] cmd_data_i,
    output logic        rsp_valid_o,
    output logic [40:0] rsp_data_o,
    output logic        tck_o,
    output logic        tms_o,
    output logic        tdi_o,
    input  logic        tdo_i
);

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_IDLE  = 2'd3;
    localparam logic [5:0] MAX_BITS = 6'd41;
    localparam logic [7:0] DIV_LAST = 8'(ClkDiv - 1);

    typedef enum logic [2:0] {IDLE, HDR, SHIFT, TRL, DONE} state_t;

    state_t      state, state_d, nxt_state;
    logic [1:0]  op;
    logic [5:0]  n, eff_len, cnt, nxt_cnt, hdr_last;
    logic [40:0] data, data_sel, rsp_data;
    logic [7:0]  div;
    logic        run, tck, tms, tdi;
    logic        accept, busy, tick, rise, fall, step, nxt_tms, nxt_tdi;

    assign accept   = (state == IDLE) && cmd_valid_i;
    assign busy     = (state == HDR) || (state == SHIFT) || (state == TRL);
    assign tick     = run && (div == DIV_LAST);
    assign rise     = tick && !tck;
    assign fall     = tick && tck;
    // HDR with run low is the one-cycle setup slot that loads the first period
    assign step     = ((state == HDR) && !run) || fall;
    assign data_sel = data >> nxt_cnt;

    always_comb begin
        eff_len = cmd_len_i;
        if (cmd_op_i != OP_IDLE) begin
            if (cmd_len_i == 6'd0)
                eff_len = 6'd1;
            else if (cmd_len_i > MAX_BITS)
                eff_len = MAX_BITS;
        end
    end

    always_comb begin
        case (op)
            OP_RESET: hdr_last = 6'd5;
            OP_IR:    hdr_last = 6'd3;
            default:  hdr_last = 6'd2;
        endcase
    end

    // Position (state, index) of the TCK period that follows the current one
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        if (!run) begin
            nxt_cnt = '0;
            if (op != OP_IDLE)
                nxt_state = HDR;
            else if (n == 6'd0)
                nxt_state = DONE;
            else
                nxt_state = SHIFT;
        end else begin
            nxt_cnt = cnt + 6'd1;
            case (state)
                HDR: if (cnt == hdr_last) begin
                    nxt_cnt   = '0;
                    nxt_state = (op == OP_RESET) ? DONE : SHIFT;
                end
                SHIFT: if (cnt == n - 6'd1) begin
                    nxt_cnt   = '0;
                    nxt_state = (op == OP_IDLE) ? DONE : TRL;
                end
                TRL: if (cnt == 6'd1) begin
                    nxt_cnt   = '0;
                    nxt_state = DONE;
                end
                default: nxt_cnt = cnt;
            endcase
        end
    end

    always_comb begin
        nxt_tms = 1'b0;
        nxt_tdi = 1'b0;
        case (nxt_state)
            HDR: begin
                case (op)
                    OP_RESET: nxt_tms = (nxt_cnt < 6'd5);
                    OP_IR:    nxt_tms = (nxt_cnt < 6'd2);
                    default:  nxt_tms = (nxt_cnt == 6'd0);
                endcase
            end
            SHIFT: if (op != OP_IDLE) begin
                nxt_tms = (nxt_cnt == n - 6'd1);
                nxt_tdi = data_sel[0];
            end
            TRL:     nxt_tms = (nxt_cnt == 6'd0);
            default: ;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (cmd_valid_i) state_d = HDR;
            DONE:    state_d = IDLE;
            default: if (step) state_d = nxt_state;
        endcase
    end

    always_ff @(posedge clk_i or negedge trst_ni) begin
        if (!trst_ni)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk_i or negedge trst_ni) begin
        if (!trst_ni) begin
            op       <= OP_RESET;
            n        <= '0;
            data     <= '0;
            cnt      <= '0;
            run      <= 1'b0;
            div      <= '0;
            tck      <= 1'b0;
            tms      <= 1'b1;
            tdi      <= 1'b0;
            rsp_data <= '0;
        end else if (accept) begin
            op       <= cmd_op_i;
            n        <= eff_len;
            data     <= cmd_data_i;
            cnt      <= '0;
            run      <= 1'b0;
            div      <= '0;
            tck      <= 1'b0;
            rsp_data <= '0;
        end else if (busy) begin
            if (step) begin
                cnt <= nxt_cnt;
                tms <= nxt_tms;
                tdi <= nxt_tdi;
                run <= (nxt_state != DONE);
            end
            if (run) begin
                if (tick) begin
                    div <= '0;
                    tck <= ~tck;
                end else begin
                    div <= div + 8'd1;
                end
            end
            if (rise && (state == SHIFT) && (op != OP_IDLE))
                rsp_data <= rsp_data | (41'(tdo_i) << cnt);
        end
    end

    assign cmd_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == DONE);
    assign rsp_data_o  = rsp_data;
    assign tck_o       = tck;
    assign tms_o       = tms;
    assign tdi_o       = tdi;

endmodule

`default_nettype wire
